// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller slice.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IMISS = 2'd1,
    ST_MDU   = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MDU_LATENCY_DEF = 4;
  localparam int         CNT_W_DEF       = 4;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller bus: ID/EX hazard sources and cache status in, pipeline-register controls out.
interface pipeline_hazard_controller_if;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_useRs;
  logic       id_useRt;
  logic       id_branchTaken;
  logic       id_mduStart;
  logic       ex_writeRegEnable;
  logic [4:0] ex_writeRegAddr;
  logic       ex_mem2Reg;
  logic       icache_miss;
  logic       icache_ready;
  logic       dcache_miss;
  logic       dcache_ready;

  logic       pc_hold;
  logic       ifid_hold;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       idex_hold;
  logic       exmem_hold;
  logic       memwb_bubble;
  logic       mdu_busy;
  logic [1:0] state;

  modport master (
    output id_rs, id_rt, id_useRs, id_useRt, id_branchTaken, id_mduStart,
           ex_writeRegEnable, ex_writeRegAddr, ex_mem2Reg,
           icache_miss, icache_ready, dcache_miss, dcache_ready,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold,
           exmem_hold, memwb_bubble, mdu_busy, state
  );

  modport slave (
    input  id_rs, id_rt, id_useRs, id_useRt, id_branchTaken, id_mduStart,
           ex_writeRegEnable, ex_writeRegAddr, ex_mem2Reg,
           icache_miss, icache_ready, dcache_miss, dcache_ready,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold,
           exmem_hold, memwb_bubble, mdu_busy, state
  );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Load-use detector: a load in EX whose destination is a source read by the ID instruction.
module hazard_load_use_detect
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_useRs_i,
  input  logic       id_useRt_i,
  input  logic       ex_writeRegEnable_i,
  input  logic [4:0] ex_writeRegAddr_i,
  input  logic       ex_mem2Reg_i,
  output logic       load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_useRs_i && (id_rs_i == ex_writeRegAddr_i);
  assign rt_hit = id_useRt_i && (id_rt_i == ex_writeRegAddr_i);

  // $zero is never a real dependency even if a load names it
  assign load_use_o = ex_mem2Reg_i && ex_writeRegEnable_i &&
                      (ex_writeRegAddr_i != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, I/D-cache miss, MDU, branch flush).
// Optional HAZARD_PERF_EN adds saturating stall/branch-flush performance counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  pipeline_hazard_controller_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                 perf_stall_cycles,
  output logic [31:0]                 perf_flush_cnt
`endif
);

  hz_state_e  state_q, state_d;
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic       dmiss_pend_q, dmiss_pend_d;
  logic       mdu_done_q, mdu_done_d;

  logic load_use;
  logic full_hold;
  logic in_run, in_imiss, in_mdu;
  logic mdu_start, stall;
  logic imiss_entry, imiss_fetch;
  logic branch_flush;
  logic pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic idex_hold, exmem_hold, memwb_bubble, mdu_busy;
  logic [1:0] state_out;

  hazard_load_use_detect u_load_use (
    .id_rs_i             (hz.id_rs),
    .id_rt_i             (hz.id_rt),
    .id_useRs_i          (hz.id_useRs),
    .id_useRt_i          (hz.id_useRt),
    .ex_writeRegEnable_i (hz.ex_writeRegEnable),
    .ex_writeRegAddr_i   (hz.ex_writeRegAddr),
    .ex_mem2Reg_i        (hz.ex_mem2Reg),
    .load_use_o          (load_use)
  );

  assign in_run   = (state_q == ST_RUN);
  assign in_imiss = (state_q == ST_IMISS);
  assign in_mdu   = (state_q == ST_MDU);

  // A D-miss freezes everything; a pending miss keeps freezing until the refill lands
  assign full_hold   = hz.dcache_miss || (dmiss_pend_q && !hz.dcache_ready);
  assign mdu_start   = in_run && hz.id_mduStart && !mdu_done_q && !load_use && !full_hold;
  assign stall       = load_use || mdu_start || in_mdu;
  // MDU entry wins over an I-miss in the same cycle; the fetch keeps missing and is taken later
  assign imiss_entry = in_run && hz.icache_miss && !full_hold && !mdu_start;
  assign imiss_fetch = imiss_entry || (in_imiss && !hz.icache_ready);
  assign branch_flush = hz.id_branchTaken && !stall && !full_hold;

  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    mdu_busy     = 1'b0;
    state_out    = ST_RUN;
    if (!reset) begin
      if (full_hold) begin
        pc_hold      = 1'b1;
        ifid_hold    = 1'b1;
        idex_hold    = 1'b1;
        exmem_hold   = 1'b1;
        memwb_bubble = 1'b1;
      end else begin
        pc_hold     = stall || imiss_fetch;
        ifid_hold   = stall;
        idex_bubble = stall;
        ifid_flush  = !stall && (imiss_fetch || hz.id_branchTaken);
      end
      mdu_busy  = in_mdu;
      state_out = state_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    mdu_cnt_d    = mdu_cnt_q;
    mdu_done_d   = 1'b0;
    dmiss_pend_d = dmiss_pend_q;
    if (hz.dcache_miss) begin
      dmiss_pend_d = 1'b1;
    end else if (hz.dcache_ready) begin
      dmiss_pend_d = 1'b0;
    end
    case (state_q)
      ST_RUN: begin
        if (mdu_start) begin
          state_d   = ST_MDU;
          mdu_cnt_d = CNT_W'(MDU_LATENCY - 1);
        end else if (imiss_entry) begin
          state_d = ST_IMISS;
        end
      end
      ST_IMISS: begin
        if (hz.icache_ready) state_d = ST_RUN;
      end
      ST_MDU: begin
        // Countdown freezes while the D-side holds the pipe
        if (!full_hold) begin
          if (mdu_cnt_q == CNT_W'(1)) begin
            state_d    = ST_RUN;
            mdu_cnt_d  = '0;
            mdu_done_d = 1'b1;
          end else begin
            mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      mdu_cnt_q    <= '0;
      dmiss_pend_q <= 1'b0;
      mdu_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mdu_cnt_q    <= mdu_cnt_d;
      dmiss_pend_q <= dmiss_pend_d;
      mdu_done_q   <= mdu_done_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pc_hold && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
      if (branch_flush && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cnt    = perf_flush_q;
`endif

  assign hz.pc_hold      = pc_hold;
  assign hz.ifid_hold    = ifid_hold;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.idex_hold    = idex_hold;
  assign hz.exmem_hold   = exmem_hold;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.mdu_busy     = mdu_busy;
  assign hz.state        = state_out;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: stimulus queues hand-computed control vectors, a negedge monitor pops and compares.
module tb_pipeline_hazard_controller;

  logic clock;
  logic reset;

  pipeline_hazard_controller_if hz ();

  pipeline_hazard_controller #(.MDU_LATENCY(4), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [9:0] exp_q[$];
  string      name_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  // {pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_hold, memwb_bubble, mdu_busy, state[1:0]}
  function automatic logic [9:0] ev(input bit pc, input bit ih, input bit fl, input bit ib,
                                    input bit ihd, input bit eh, input bit mb, input bit busy,
                                    input logic [1:0] st);
    return {pc, ih, fl, ib, ihd, eh, mb, busy, st};
  endfunction

  localparam logic [1:0] RUN = 2'd0, IMS = 2'd1, MDU = 2'd2;

  task automatic idle_inputs();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_useRs = 1'b0; hz.id_useRt = 1'b0;
    hz.id_branchTaken = 1'b0; hz.id_mduStart = 1'b0;
    hz.ex_writeRegEnable = 1'b0; hz.ex_writeRegAddr = 5'd0; hz.ex_mem2Reg = 1'b0;
    hz.icache_miss = 1'b0; hz.icache_ready = 1'b0;
    hz.dcache_miss = 1'b0; hz.dcache_ready = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] addr);
    hz.ex_mem2Reg = 1'b1; hz.ex_writeRegEnable = 1'b1; hz.ex_writeRegAddr = addr;
  endtask

  // Inputs for this cycle are already applied; queue the expectation and advance one clock.
  task automatic cyc(input string nm, input logic [9:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      logic [9:0] a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.idex_bubble, hz.idex_hold,
            hz.exmem_hold, hz.memwb_bubble, hz.mdu_busy, hz.state};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Reset dominates even with hazard sources active
    hz.dcache_miss = 1'b1; hz.id_mduStart = 1'b1;
    cyc("reset_outputs", '0);
    idle_inputs();
    reset = 1'b0;
    cyc("idle_run", ev(0,0,0,0,0,0,0,0,RUN));

    // Load-use on rs, then free
    set_load(5'd5); hz.id_useRs = 1'b1; hz.id_rs = 5'd5;
    cyc("load_use_rs", ev(1,1,0,1,0,0,0,0,RUN));
    hz.ex_mem2Reg = 1'b0;
    cyc("after_load_use", ev(0,0,0,0,0,0,0,0,RUN));
    set_load(5'd0); hz.id_rs = 5'd0;
    cyc("load_to_r0", ev(0,0,0,0,0,0,0,0,RUN));
    idle_inputs(); set_load(5'd7); hz.id_useRt = 1'b1; hz.id_rt = 5'd7;
    cyc("load_use_rt", ev(1,1,0,1,0,0,0,0,RUN));
    hz.id_useRt = 1'b0;
    cyc("rt_not_read", ev(0,0,0,0,0,0,0,0,RUN));
    idle_inputs();

    // MDU: exactly 4 stall cycles, no re-trigger on the same instruction
    hz.id_mduStart = 1'b1;
    cyc("mdu_c1_start", ev(1,1,0,1,0,0,0,0,RUN));
    cyc("mdu_c2", ev(1,1,0,1,0,0,0,1,MDU));
    cyc("mdu_c3", ev(1,1,0,1,0,0,0,1,MDU));
    cyc("mdu_c4", ev(1,1,0,1,0,0,0,1,MDU));
    cyc("mdu_no_5th", ev(0,0,0,0,0,0,0,0,RUN));
    idle_inputs();
    cyc("mdu_after", ev(0,0,0,0,0,0,0,0,RUN));

    // MDU interrupted by a D-miss: 3 full-hold cycles, 7 pc_hold cycles in total
    hz.id_mduStart = 1'b1;
    cyc("mdud_c1_start", ev(1,1,0,1,0,0,0,0,RUN));
    hz.dcache_miss = 1'b1;
    cyc("mdud_c2_dmiss", ev(1,1,0,0,1,1,1,1,MDU));
    hz.dcache_miss = 1'b0;
    cyc("mdud_c3_pend", ev(1,1,0,0,1,1,1,1,MDU));
    cyc("mdud_c4_pend", ev(1,1,0,0,1,1,1,1,MDU));
    hz.dcache_ready = 1'b1;
    cyc("mdud_c5_ready", ev(1,1,0,1,0,0,0,1,MDU));
    hz.dcache_ready = 1'b0;
    cyc("mdud_c6", ev(1,1,0,1,0,0,0,1,MDU));
    cyc("mdud_c7", ev(1,1,0,1,0,0,0,1,MDU));
    cyc("mdud_done", ev(0,0,0,0,0,0,0,0,RUN));
    idle_inputs();

    // I-miss: 5 cycles of pc_hold+flush, release on the ready cycle
    hz.icache_miss = 1'b1;
    cyc("imiss_entry", ev(1,0,1,0,0,0,0,0,RUN));
    hz.icache_miss = 1'b0;
    cyc("imiss_w1", ev(1,0,1,0,0,0,0,0,IMS));
    hz.id_branchTaken = 1'b1;
    cyc("imiss_w2_branch", ev(1,0,1,0,0,0,0,0,IMS));
    hz.id_branchTaken = 1'b0;
    cyc("imiss_w3", ev(1,0,1,0,0,0,0,0,IMS));
    cyc("imiss_w4", ev(1,0,1,0,0,0,0,0,IMS));
    hz.icache_ready = 1'b1;
    cyc("imiss_ready", ev(0,0,0,0,0,0,0,0,IMS));
    hz.icache_ready = 1'b0;
    cyc("imiss_back_run", ev(0,0,0,0,0,0,0,0,RUN));

    // I-miss entry with load-use: hold instead of flush
    hz.icache_miss = 1'b1; set_load(5'd9); hz.id_useRs = 1'b1; hz.id_rs = 5'd9;
    cyc("imiss_lu_entry", ev(1,1,0,1,0,0,0,0,RUN));
    idle_inputs(); hz.icache_ready = 1'b1;
    cyc("imiss_lu_ready", ev(0,0,0,0,0,0,0,0,IMS));
    idle_inputs();

    // Branch with load-use: stall wins; branch alone next cycle flushes
    hz.id_branchTaken = 1'b1; set_load(5'd3); hz.id_useRt = 1'b1; hz.id_rt = 5'd3;
    cyc("branch_lu", ev(1,1,0,1,0,0,0,0,RUN));
    hz.ex_mem2Reg = 1'b0;
    cyc("branch_alone", ev(0,0,1,0,0,0,0,0,RUN));
    idle_inputs();

    // Branch under D-miss hold, then released on ready
    hz.id_branchTaken = 1'b1; hz.dcache_miss = 1'b1;
    cyc("branch_dmiss", ev(1,1,0,0,1,1,1,0,RUN));
    hz.dcache_miss = 1'b0; hz.dcache_ready = 1'b1;
    cyc("branch_dready", ev(0,0,1,0,0,0,0,0,RUN));
    idle_inputs();

    // Reset in the middle of an MDU op with a D-miss pending
    hz.id_mduStart = 1'b1;
    cyc("rst_mdu_start", ev(1,1,0,1,0,0,0,0,RUN));
    hz.dcache_miss = 1'b1;
    cyc("rst_mdu_dmiss", ev(1,1,0,0,1,1,1,1,MDU));
    hz.dcache_miss = 1'b0; reset = 1'b1;
    cyc("rst_mid_op", '0);
    reset = 1'b0; hz.id_mduStart = 1'b0;
    cyc("rst_cleared", ev(0,0,0,0,0,0,0,0,RUN));
    hz.id_mduStart = 1'b1;
    cyc("rst_mdu_restart", ev(1,1,0,1,0,0,0,0,RUN));
    idle_inputs(); reset = 1'b1;
    cyc("rst_again", '0);
    reset = 1'b0;
    cyc("final_idle", ev(0,0,0,0,0,0,0,0,RUN));

    @(posedge clock);
    @(posedge clock);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
